icache_dm: RTL
==============

# icache_dm

Direct-mapped, read-only instruction cache between the fetch stage's instruction-address port and the memory arbiter's fetch-side request port. Hits return the instruction word in the same cycle. On a miss, the block fills the whole line by issuing `WORDS_PER_LINE` sequential 16-bit reads to memory, then serves the hit. Fetch holds its request until the cache asserts `cpu_resp`.

## Interface
- `NUM_LINES`, default 8: number of lines; power of 2, ≥ 2.
- `WORDS_PER_LINE`, default 8: 16-bit words per line; power of 2, ≥ 2.
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `cpu_read`, in, 1: fetch request; held until `cpu_resp`.
- `cpu_address`, in, 16: byte address; bit 0 is ignored.
- `cpu_rdata`, out, 16: instruction word; valid only when `cpu_resp`=1, otherwise 16'h0000.
- `cpu_resp`, out, 1: request complete (hit this cycle).
- `flush`, in, 1: single-cycle pulse that invalidates all lines.
- `mem_read`, out, 1: read request toward the arbiter.
- `mem_address`, out, 16: word-aligned fill address (bit 0 = 0).
- `mem_rdata`, in, 16: fill data.
- `mem_resp`, in, 1: one-cycle pulse; `mem_rdata` is valid in the same cycle.

## Operation
- Address split, with O = log2(WORDS_PER_LINE) and I = log2(NUM_LINES):
  - offset = `cpu_address[O:1]`
  - index = `cpu_address[O+I:O+1]`
  - tag = `cpu_address[15:O+I+1]`
  - With defaults: offset [3:1], index [6:4], tag [15:7] (9 bits).
- Storage per line: valid bit, tag, `WORDS_PER_LINE` words. Only valid bits are reset; data and tag arrays are not reset.
- Hit = `cpu_read` & valid[index] & (tag_array[index] == tag). Evaluated only in IDLE.
- State IDLE:
  - On hit: `cpu_resp`=1 and `cpu_rdata`=word[index][offset], combinationally. Stay in IDLE.
  - On `cpu_read` & !hit: latch tag and index, clear word counter `cnt` to 0, go to FILL. `cpu_resp`=0.
  - On `flush`: clear all valid bits at the edge. If `cpu_read` is also high that cycle, the lookup uses the pre-flush valid bits.
- State FILL:
  - Drive `mem_read`=1 and `mem_address`={latched tag, latched index, cnt, 1'b0}.
  - On `mem_resp`: write `mem_rdata` into word[latched index][cnt] and increment `cnt`.
  - On `mem_resp` with `cnt`==WORDS_PER_LINE−1: write the tag, set valid (unless a flush is pending), and go to IDLE.
  - `cpu_resp` stays 0 throughout FILL.
- Flush during FILL is latched as pending. At the fill-completion edge, the pending flush clears all valid bits, including the line just filled, and then the pending flag is cleared.
- Fill is never aborted by `cpu_read` dropping or `cpu_address` changing. The new address is looked up after the return to IDLE.
- `mem_resp` received outside FILL is ignored.
- Line replacement is unconditional overwrite. There is no write path and no dirty state.

## Timing
- Reset (`rst_n`=0 at an edge) forces:
  - state=IDLE, `cnt`=0, all valid bits=0, pending flush=0.
  - Outputs for the rest of that cycle and after: `mem_read`=0, `cpu_resp`=0, `cpu_rdata`=0.
- Reset mid-fill: the fill is abandoned and the line stays invalid. `mem_read` is low from the cycle after the reset edge.
- Hit latency: 0 cycles; `cpu_resp` is asserted in the same cycle as `cpu_read`.
- Miss latency:
  - 1 cycle in IDLE to detect the miss.
  - Then each of the W = WORDS_PER_LINE fill reads takes its memory latency.
  - Then 1 cycle in IDLE for the hit.
  - Total: sum of the W memory latencies + 2 cycles.
- `mem_read` is asserted continuously from the first FILL cycle until the edge carrying the last `mem_resp`.
- `mem_address` is stable during each word request and advances in the cycle after each `mem_resp`.
- `mem_read` is low in the cycle after the final `mem_resp`.
- Wrap-around: `cnt` counts 0..W−1 and never wraps within a fill. Fill addresses never cross the line boundary. Line base 0xFFF0 fills 0xFFF0..0xFFFE.

## Test plan
- Cold miss then hit. Memory returns data = address, with 2-cycle latency. Reset, then read 0x0040.
  - Required: 8 reads to 0x0040, 0x0042, …, 0x004E.
  - Then `cpu_resp` with 0x0040 exactly 2 + 8×2 cycles after the request.
  - A subsequent read of 0x004A hits in the same cycle, returns 0x004A, and `mem_read` stays 0.
- Conflict: read 0x0040 and then 0x00C0 (both index 4, tags 0x000 and 0x001).
  - Required: a second full fill from 0x00C0.
  - Re-reading 0x0040 misses and refills.
  - Reading 0x0050 (index 5) while 0x00C0 is resident is also a miss.
- Reset mid-fill: assert `rst_n`=0 after the 3rd `mem_resp` of a fill for 0x0040.
  - Required: `mem_read`=0 the next cycle.
  - After reset, reading 0x0044 triggers a full 8-word fill starting at 0x0040.
- Flush:
  - Fill 0x0040, pulse `flush` in IDLE: the next read of 0x0040 misses.
  - Pulse `flush` during a fill of 0x0080: after the fill completes, `cpu_resp` stays 0, state returns to FILL, and 0x0080 is re-fetched.
- Robustness:
  - Random `mem_resp` latency of 0–5 cycles: fill data must be correct at every offset.
  - Stray `mem_resp` pulses in IDLE: no state change.
  - Dropping `cpu_read` mid-fill: the fill completes, the line is valid, and no `cpu_resp` is issued.
- Top of memory: read 0xFFFE.
  - Required: fill 0xFFF0..0xFFFE into index 7 with tag 0x1FF, and `cpu_rdata`=0xFFFE.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: same-cycle hits, whole-line fill
// on a miss using sequential word reads from the fetch-side memory port.
module icache_dm #(
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_read,
  input  logic [15:0] cpu_address,
  output logic [15:0] cpu_rdata,
  output logic        cpu_resp,
  input  logic        flush,
  output logic        mem_read,
  output logic [15:0] mem_address,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp
);

  localparam int O  = $clog2(WORDS_PER_LINE);
  localparam int I  = $clog2(NUM_LINES);
  localparam int TW = 15 - O - I;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [O-1:0]         req_off;
  logic [I-1:0]         req_idx;
  logic [TW-1:0]        req_tag;
  logic                 unused_bit0;

  logic [O-1:0]         cnt;
  logic [I-1:0]         fill_idx;
  logic [TW-1:0]        fill_tag;
  logic [NUM_LINES-1:0] valid;
  logic                 flush_pend;

  logic [TW-1:0]        tag_arr  [NUM_LINES];
  logic [15:0]          data_arr [NUM_LINES][WORDS_PER_LINE];

  logic                 hit;
  logic                 start_fill;
  logic                 fill_done;

  assign req_off     = cpu_address[O:1];
  assign req_idx     = cpu_address[O+I:O+1];
  assign req_tag     = cpu_address[15:O+I+1];
  assign unused_bit0 = cpu_address[0];

  always_comb begin
    state_nxt  = state;
    hit        = 1'b0;
    start_fill = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        hit        = cpu_read & valid[req_idx] & (tag_arr[req_idx] == req_tag);
        start_fill = cpu_read & ~hit;
        if (start_fill) state_nxt = FILL;
      end
      FILL: begin
        // Counter is a power-of-two width, so all-ones marks the last word.
        fill_done = mem_resp & (&cnt);
        if (fill_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held.
  assign cpu_resp    = rst_n & hit;
  assign cpu_rdata   = cpu_resp ? data_arr[req_idx][req_off] : 16'h0000;
  assign mem_read    = rst_n & (state == FILL);
  assign mem_address = {fill_tag, fill_idx, cnt, 1'b0};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      valid      <= '0;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_fill) cnt <= '0;
          if (flush) valid <= '0;
        end
        FILL: begin
          if (mem_resp) cnt <= cnt + 1'b1;
          if (fill_done) begin
            // A flush seen at any point of the fill also kills the new line.
            if (flush_pend || flush) valid <= '0;
            else                     valid[fill_idx] <= 1'b1;
            flush_pend <= 1'b0;
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (start_fill) begin
      fill_tag <= req_tag;
      fill_idx <= req_idx;
    end
    if (state == FILL && mem_resp) data_arr[fill_idx][cnt] <= mem_rdata;
    if (fill_done) tag_arr[fill_idx] <= fill_tag;
  end

endmodule
